inst_rom_loader: RTL and testbench

- Instruction-memory responder for the openmips fetch port: it answers the core's rom_ce/rom_addr requests with instruction words.
- Adds a sequential byte-stream load port (valid/ready) that assembles bytes into big-endian words and writes them from word 0 upward.
- Sits between the core's fetch outputs/inputs and a host/UART-side loader; replaces a static ROM.

---
 rtl/inst_rom_loader.sv | 151 +++++++++++++++
 tb/tb_inst_rom_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// ---------------------------------------------------------------------------
// inst_rom_loader
//
// Instruction memory for the openmips fetch port with a byte-stream loader.
// Fetch reads are combinational so if_id captures the word on the same edge
// as the pc. The load port packs incoming bytes big-endian into 32-bit words
// and writes them sequentially from word 0 upward.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   rom_ce_i     fetch enable from core
//   rom_addr_i   fetch byte address from core (bits [1:0] ignored)
//   rom_data_o   instruction word to core, 0 (NOP) when gated
//   load_start   pulse: enter or restart load mode
//   load_end     pulse: leave load mode
//   load_valid   byte offered on load_byte
//   load_byte    byte data
//   load_ready   byte can be accepted this cycle
//   loading      high while in LOAD state
//   word_count   words written in the current/last load
//   load_err     sticky: partial word dropped or overflow
// ---------------------------------------------------------------------------
module inst_rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              loading,
    output logic [ADDR_W:0]   word_count,
    output logic              load_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_LOAD = 1'b1;

    localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

    // Memory is deliberately not reset so a program survives a core reset.
    logic [31:0] mem [0:DEPTH-1];

    logic [0:0]      state_reg,      state_next;
    logic [1:0]      byte_cnt_reg,   byte_cnt_next;
    logic [ADDR_W:0] wptr_reg,       wptr_next;
    logic [ADDR_W:0] word_count_reg, word_count_next;
    logic            load_err_reg,   load_err_next;
    logic [23:0]     asm_reg,        asm_next;

    logic            accept;
    logic            wptr_full;
    logic            mem_we;
    logic [31:0]     mem_wdata;

    // ---------------- fetch path ----------------
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_in_range;
    logic              addr_lsb_unused;

    assign rd_idx          = rom_addr_i[ADDR_W+1:2];
    assign rd_in_range     = (rom_addr_i[31:ADDR_W+2] == '0);
    assign addr_lsb_unused = ^rom_addr_i[1:0];

    always_comb begin
        rom_data_o = 32'h0;
        if (rst && rom_ce_i && (state_reg == ST_RUN) && rd_in_range)
            rom_data_o = mem[rd_idx];
    end

    // ---------------- load control ----------------
    // wptr has one extra bit; its MSB set means every word has been written.
    assign wptr_full  = wptr_reg[ADDR_W];
    assign load_ready = (state_reg == ST_LOAD) && !wptr_full;
    assign accept     = load_valid && load_ready;
    assign loading    = (state_reg == ST_LOAD);
    assign word_count = word_count_reg;
    assign load_err   = load_err_reg;

    // The 4th byte completes the word from the three held bytes plus the
    // byte on the bus, so the write happens on the accepting edge itself.
    assign mem_wdata = {asm_reg, load_byte};
    assign mem_we    = accept && !load_start && (byte_cnt_reg == 2'd3);

    always_comb begin
        state_next      = state_reg;
        byte_cnt_next   = byte_cnt_reg;
        wptr_next       = wptr_reg;
        word_count_next = word_count_reg;
        load_err_next   = load_err_reg;
        asm_next        = asm_reg;

        if (load_start) begin
            // Restart wins over load_end and over any byte on the same edge.
            state_next      = ST_LOAD;
            byte_cnt_next   = 2'd0;
            wptr_next       = '0;
            word_count_next = '0;
            load_err_next   = 1'b0;
        end else if (state_reg == ST_LOAD) begin
            if (accept) begin
                asm_next      = {asm_reg[15:0], load_byte};
                byte_cnt_next = byte_cnt_reg + 2'd1;
                if (byte_cnt_reg == 2'd3) begin
                    wptr_next       = wptr_reg + ONE_W;
                    word_count_next = word_count_reg + ONE_W;
                end
            end else if (load_valid && wptr_full) begin
                load_err_next = 1'b1;
            end
            // The byte on this edge is counted before judging the tail.
            if (load_end) begin
                state_next = ST_RUN;
                if (byte_cnt_next != 2'd0)
                    load_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_RUN;
            byte_cnt_reg   <= 2'd0;
            wptr_reg       <= '0;
            word_count_reg <= '0;
            load_err_reg   <= 1'b0;
            asm_reg        <= 24'h0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            wptr_reg       <= wptr_next;
            word_count_reg <= word_count_next;
            load_err_reg   <= load_err_next;
            asm_reg        <= asm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wptr_reg[ADDR_W-1:0]] <= mem_wdata;
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_loader
//
// Directed bench for inst_rom_loader. Two instances share all inputs: a
// full-size one (ADDR_W=10) and a tiny one (ADDR_W=2) that exercises
// overflow. Inputs change on the falling edge; outputs are sampled on the
// falling edge or shortly after a combinational input change.
// ---------------------------------------------------------------------------
module tb_inst_rom_loader;

    logic        clk;
    logic        rst;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic        load_start;
    logic        load_end;
    logic        load_valid;
    logic [7:0]  load_byte;

    logic [31:0] rom_data;
    logic        load_ready;
    logic        loading;
    logic [10:0] word_count;
    logic        load_err;

    logic [31:0] s_rom_data;
    logic        s_load_ready;
    logic        s_loading;
    logic [2:0]  s_word_count;
    logic        s_load_err;

    int checks;
    int errors;

    inst_rom_loader #(.ADDR_W(10)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data),
        .load_start (load_start),
        .load_end   (load_end),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .loading    (loading),
        .word_count (word_count),
        .load_err   (load_err)
    );

    inst_rom_loader #(.ADDR_W(2)) u_small (
        .clk        (clk),
        .rst        (rst),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (s_rom_data),
        .load_start (load_start),
        .load_end   (load_end),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (s_load_ready),
        .loading    (s_loading),
        .word_count (s_word_count),
        .load_err   (s_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        @(negedge clk);
        load_end = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic ce, input logic [31:0] addr,
                         input logic [31:0] exp);
        rom_ce_i   = ce;
        rom_addr_i = addr;
        #1;
        chk(tag, rom_data, exp);
        $display("fetch %s ce=%0b addr=%h data=%h", tag, ce, addr, rom_data);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h0;
        load_start = 1'b0;
        load_end   = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;

        // ---- reset held for 3 cycles ----
        repeat (3) @(negedge clk);
        chk("rst_loading",    {31'b0, loading},      32'h0);
        chk("rst_ready",      {31'b0, load_ready},   32'h0);
        chk("rst_word_count", {21'b0, word_count},   32'h0);
        chk("rst_err",        {31'b0, load_err},     32'h0);
        chk("rst_rom_data",   rom_data,              32'h0);
        rst = 1'b1;
        @(negedge clk);

        // ---- basic two-word load ----
        pulse_start();
        chk("ld_loading", {31'b0, loading},    32'h1);
        chk("ld_ready",   {31'b0, load_ready}, 32'h1);
        send_byte(8'h34); send_byte(8'h02); send_byte(8'h00); send_byte(8'h0A);
        send_byte(8'h34); send_byte(8'h03); send_byte(8'h00); send_byte(8'h0B);
        pulse_end();
        chk("ld_word_count", {21'b0, word_count}, 32'h2);
        chk("ld_err",        {31'b0, load_err},   32'h0);
        chk("ld_loading_end",{31'b0, loading},    32'h0);
        $display("load: word_count=%0d err=%0b", word_count, load_err);
        fetch("fetch_a0", 1'b1, 32'h0, 32'h3402000A);
        fetch("fetch_a4", 1'b1, 32'h4, 32'h3403000B);
        fetch("fetch_a5", 1'b1, 32'h5, 32'h3403000B);

        // ---- fetch gating ----
        fetch("fetch_ce0",    1'b0, 32'h0,         32'h0);
        fetch("fetch_oor",    1'b1, 32'h0000_1000, 32'h0);
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h10;
        #1;
        chk("small_oor", s_rom_data, 32'h0);
        rom_addr_i = 32'h4;
        #1;
        chk("small_a4", s_rom_data, 32'h3403000B);
        @(negedge clk);

        // ---- partial word (fetch gated while loading) ----
        pulse_start();
        fetch("fetch_in_load", 1'b1, 32'h0, 32'h0);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        pulse_end();
        chk("part_err",        {31'b0, load_err},   32'h1);
        chk("part_word_count", {21'b0, word_count}, 32'h0);
        $display("partial: word_count=%0d err=%0b", word_count, load_err);
        fetch("part_mem0", 1'b1, 32'h0, 32'h3402000A);

        // ---- 4th byte coincident with load_end ----
        pulse_start();
        chk("co_err_cleared", {31'b0, load_err}, 32'h0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        load_valid = 1'b1;
        load_byte  = 8'h44;
        load_end   = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        load_end   = 1'b0;
        chk("co_word_count", {21'b0, word_count}, 32'h1);
        chk("co_err",        {31'b0, load_err},   32'h0);
        chk("co_loading",    {31'b0, loading},    32'h0);
        $display("coincide: word_count=%0d err=%0b loading=%0b", word_count, load_err, loading);
        fetch("co_mem0", 1'b1, 32'h0, 32'h11223344);

        // ---- load_start and load_end together: start wins ----
        load_start = 1'b1;
        load_end   = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        load_end   = 1'b0;
        chk("se_loading",    {31'b0, loading},    32'h1);
        chk("se_word_count", {21'b0, word_count}, 32'h0);

        // ---- overflow on the 4-word instance ----
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i));
            if (i == 14) chk("ovf_ready_15", {31'b0, s_load_ready}, 32'h1);
            if (i == 15) chk("ovf_ready_16", {31'b0, s_load_ready}, 32'h0);
        end
        chk("ovf_word_count", {29'b0, s_word_count}, 32'h4);
        chk("ovf_err",        {31'b0, s_load_err},   32'h1);
        chk("big_word_count", {21'b0, word_count},   32'h5);
        chk("big_err",        {31'b0, load_err},     32'h0);
        $display("overflow: small wc=%0d err=%0b, big wc=%0d err=%0b",
                 s_word_count, s_load_err, word_count, load_err);
        pulse_end();
        rom_addr_i = 32'hC;
        #1;
        chk("ovf_small_w3", s_rom_data, 32'h0C0D0E0F);
        fetch("ovf_big_w4", 1'b1, 32'h10, 32'h10111213);
        @(negedge clk);

        // ---- asynchronous reset mid-load ----
        pulse_start();
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
        send_byte(8'hA3); send_byte(8'hA4); send_byte(8'hA5);
        chk("ar_word_count_pre", {21'b0, word_count}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_loading",    {31'b0, loading},    32'h0);
        chk("ar_ready",      {31'b0, load_ready}, 32'h0);
        chk("ar_word_count", {21'b0, word_count}, 32'h0);
        chk("ar_rom_data",   rom_data,            32'h0);
        $display("async reset: loading=%0b wc=%0d", loading, word_count);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ar_loading_after", {31'b0, loading}, 32'h0);
        fetch("ar_mem0", 1'b1, 32'h0, 32'hA0A1A2A3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
